mod_line_doubler: RTL and testbench
===================================

# mod_line_doubler

Line-buffered 2× scaler between the NES picture source and `mod_vga_encoder`. It accepts one 256-pixel source line at a time into a ping-pong line RAM and replays each line twice, horizontally doubled, as a 512×480 window centred in the 640×480 VGA active area. It is addressed by the encoder's current x/y and drives the encoder's r/g/b inputs.

## Interface
- `H_ACTIVE`, 640, VGA active pixels per line
- `V_ACTIVE`, 480, VGA active lines
- `V_TOTAL`, 525, VGA lines per frame, blanking included
- `SRC_W`, 256, source pixels per line
- `SRC_H`, 240, source lines per frame
- `X_OFFSET`, 64, first VGA x of the window
- `in_clk_25_175_mhz`  in  1  pixel clock; the only clock
- `in_reset`  in  1  synchronous, active-high reset
- `in_vga_x`  in  10  encoder current x, 0..799
- `in_vga_y`  in  10  encoder current y, 0..524
- `in_wr_valid`  in  1  source pixel valid
- `in_wr_rgb`  in  3  source pixel {r,g,b}
- `out_wr_ready`  out  1  back bank accepting pixels
- `out_line_req`  out  1  one-cycle pulse: fill back bank with line `out_line_idx`
- `out_line_idx`  out  8  requested source line, 0..239
- `out_vga_r`, `out_vga_g`, `out_vga_b`  out  1 each  pixel to encoder
- `out_underrun_count`  out  8  saturating count of missed swaps

## Operation
- Two banks of `SRC_W`×3 bits. Front bank is read; back bank is written. The `front_sel` bit selects the banks.
- Write side: a write is accepted when `in_wr_valid && out_wr_ready`. `waddr` (9 bits) increments on each accepted write. At `waddr == SRC_W` the back bank is full and `out_wr_ready` drops.
- A swap event fires at `in_vga_x == H_ACTIVE` when either:
  - `in_vga_y` is odd and `< V_ACTIVE-1`, or
  - `in_vga_y == V_TOTAL-1`.
- No event fires at y = 479.
- On a swap event with the back bank full:
  - toggle `front_sel`, set front valid, clear `waddr`;
  - next cycle pulse `out_line_req`.
  - `out_line_idx` is 1 after the y = 524 event. After an odd-y event it is (y+3)/2, or 0 if that is ≥ `SRC_H`.
- On a swap event with the back bank not full (underrun):
  - no toggle; the front line repeats;
  - `out_underrun_count` increments, saturating at 255;
  - `waddr` clears and the request is reissued with the new index.
- FSM:
  - SYNC (reset state): issue a request for line 0 one cycle after reset deasserts. Ignore odd-y events; the y = 524 event → RUN.
  - RUN: the rules above.
- Read side: inside the window (x in [`X_OFFSET`, `X_OFFSET+511`], y < `V_ACTIVE`), read address = (x − `X_OFFSET`) >> 1.
- Output is black outside the window, during blanking, or while front is invalid.

## Timing
- Read latency is 1 cycle. The out rgb registered at edge n corresponds to `in_vga_x`/`in_vga_y` sampled at edge n−1. The encoder delays hsync/vsync by one cycle to match.
- Window, blank, and valid qualifiers are pipelined 1 cycle alongside the RAM read.
- Reset values:
  - all rgb outputs 0;
  - `out_wr_ready` 0, `out_line_req` 0, `out_line_idx` 0, `out_underrun_count` 0;
  - front invalid, `waddr` 0, state SYNC.
- `out_wr_ready` rises in the same cycle as `out_line_req`. It stays high until the 256th accepted write and falls the cycle after it.
- Swap event coinciding with the final write: that write counts, so the bank is full and the swap succeeds.
- Reset asserted mid-fill or mid-frame: state returns to SYNC and the display is black until the next y = 524 event.

## Configuration
- `LINE_DOUBLER_SCANLINE_EN`
  - Defined: odd VGA lines output black inside the window; the RAM is still read and swap timing is unchanged.
  - Undefined: both copies of each line are displayed.

## Structure
- Shared package `mod_display_pkg`: VGA timing constants (640/800/480/525), NES source dimensions, window offset, and the rgb pixel width.
- One sub-module, `mod_line_ram`: single bank, `SRC_W`×3 bits, one write port and one synchronous-read port, instantiated twice.

## Test plan
- Reset, then a frame with an instant writer: `out_line_req` pulses with idx 0 one cycle after reset; the display stays black until y = 524, then the y = 0 and y = 1 lines show line 0.
- Writer supplies pixel value = x mod 8: at VGA x = 64 and 65 the output is 0; at x = 66 and 67 it is 1; x = 63 and x = 576 are black; output lags x by 1 cycle.
- Writer stalls line 5 until after the y = 9 event: the count goes to 1, lines 8–11 repeat line 4, a request for line 6 is issued, and the sequence resumes.
- End of frame: the request after the y = 477 swap has idx 0, no event fires at y = 479, and the y = 524 swap is followed by a request with idx 1.
- Reset pulsed at y = 200 mid-fill: all outputs return to reset values, SYNC ignores the odd-y events, and the display resumes after y = 524.
- With `LINE_DOUBLER_SCANLINE_EN` defined: every odd y inside the window is black, and even lines match the undefined build.

Source files
------------

// File: rtl/mod_display_pkg.sv
// Shared display constants and pixel payload type for the NES-to-VGA path.
// Also holds the line doubler FSM state type.
package mod_display_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_TOTAL  = 525;
  localparam int unsigned SRC_W    = 256;
  localparam int unsigned SRC_H    = 240;
  localparam int unsigned X_OFFSET = 64;
  localparam int unsigned RGB_W    = 3;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned LINE_W   = 8;
  localparam int unsigned CNT_W    = 8;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } ld_state_t;

endpackage

// File: rtl/mod_line_ram.sv
// One source-line bank: single write port, synchronous read port.
module mod_line_ram
  import mod_display_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  rgb_t              wdata,
  input  logic [ADDR_W-1:0] raddr,
  output rgb_t              rdata
);

  rgb_t mem [SRC_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/mod_line_doubler.sv
// Ping-pong line buffer replaying each NES line twice, 2x wide, centred in VGA.
// Optional build macro LINE_DOUBLER_SCANLINE_EN blanks odd VGA lines in the window.
module mod_line_doubler
  import mod_display_pkg::*;
(
  input  logic               in_clk_25_175_mhz,
  input  logic               in_reset,
  input  logic [COORD_W-1:0] in_vga_x,
  input  logic [COORD_W-1:0] in_vga_y,
  input  logic               in_wr_valid,
  input  logic [RGB_W-1:0]   in_wr_rgb,
  output logic               out_wr_ready,
  output logic               out_line_req,
  output logic [LINE_W-1:0]  out_line_idx,
  output logic               out_vga_r,
  output logic               out_vga_g,
  output logic               out_vga_b,
  output logic [CNT_W-1:0]   out_underrun_count
);

  localparam int unsigned WADDR_W = 9;
  localparam int unsigned YH_W    = COORD_W + 1;
  localparam logic [WADDR_W-1:0] WADDR_FULL = WADDR_W'(SRC_W);
  localparam logic [WADDR_W-1:0] WADDR_LAST = WADDR_W'(SRC_W - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

  ld_state_t           state, state_nxt;
  logic [WADDR_W-1:0]  waddr, waddr_nxt;
  logic                front_sel, front_sel_nxt;
  logic                front_valid, front_valid_nxt;
  logic                req_pend, req_pend_nxt;
  logic                wr_ready_nxt, line_req_nxt;
  logic [LINE_W-1:0]   line_idx_nxt;
  logic [CNT_W-1:0]    underrun_nxt;

  logic                swap_x, odd_evt, end_evt, evt, accept, full;
  logic [YH_W-1:0]     half_y;
  logic [LINE_W-1:0]   evt_idx;

  // Swap-event decode and the source line to request after it
  always_comb begin
    swap_x  = (in_vga_x == COORD_W'(H_ACTIVE));
    odd_evt = swap_x && in_vga_y[0] && (in_vga_y < COORD_W'(V_ACTIVE - 1));
    end_evt = swap_x && (in_vga_y == COORD_W'(V_TOTAL - 1));
    evt     = end_evt || (odd_evt && (state == ST_RUN));
    accept  = in_wr_valid && out_wr_ready;
    // a write landing on the event edge completes the bank
    full    = (waddr == WADDR_FULL) || (accept && (waddr == WADDR_LAST));
    half_y  = ({1'b0, in_vga_y} + YH_W'(3)) >> 1;
    if (end_evt) begin
      evt_idx = LINE_W'(1);
    end else if (half_y >= YH_W'(SRC_H)) begin
      evt_idx = '0;
    end else begin
      evt_idx = LINE_W'(half_y);
    end
  end

  always_ff @(posedge in_clk_25_175_mhz) begin
    if (in_reset) begin
      state <= ST_SYNC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if ((state == ST_SYNC) && end_evt) begin
      state_nxt = ST_RUN;
    end
  end

  // Next values for the write side, bank select and request outputs
  always_comb begin
    waddr_nxt       = waddr;
    front_sel_nxt   = front_sel;
    front_valid_nxt = front_valid;
    req_pend_nxt    = req_pend;
    wr_ready_nxt    = out_wr_ready;
    line_req_nxt    = 1'b0;
    line_idx_nxt    = out_line_idx;
    underrun_nxt    = out_underrun_count;

    if (accept) begin
      waddr_nxt = waddr + WADDR_W'(1);
      if (waddr == WADDR_LAST) begin
        wr_ready_nxt = 1'b0;
      end
    end

    if (req_pend) begin
      line_req_nxt = 1'b1;
      wr_ready_nxt = 1'b1;
      req_pend_nxt = 1'b0;
    end

    if (evt) begin
      waddr_nxt    = '0;
      wr_ready_nxt = 1'b0;
      req_pend_nxt = 1'b1;
      line_idx_nxt = evt_idx;
      if (full) begin
        front_sel_nxt   = ~front_sel;
        front_valid_nxt = 1'b1;
      end else if (out_underrun_count != CNT_MAX) begin
        underrun_nxt = out_underrun_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge in_clk_25_175_mhz) begin
    if (in_reset) begin
      waddr              <= '0;
      front_sel          <= 1'b0;
      front_valid        <= 1'b0;
      req_pend           <= 1'b1;
      out_wr_ready       <= 1'b0;
      out_line_req       <= 1'b0;
      out_line_idx       <= '0;
      out_underrun_count <= '0;
    end else begin
      waddr              <= waddr_nxt;
      front_sel          <= front_sel_nxt;
      front_valid        <= front_valid_nxt;
      req_pend           <= req_pend_nxt;
      out_wr_ready       <= wr_ready_nxt;
      out_line_req       <= line_req_nxt;
      out_line_idx       <= line_idx_nxt;
      out_underrun_count <= underrun_nxt;
    end
  end

  logic              in_win, show, show_q, sel_q;
  logic [ADDR_W-1:0] raddr;
  rgb_t              rd0, rd1, pix;

  // Read side: window decode, qualifiers travel alongside the RAM read
  always_comb begin
    in_win = (in_vga_x >= COORD_W'(X_OFFSET)) &&
             (in_vga_x <  COORD_W'(X_OFFSET + 2 * SRC_W)) &&
             (in_vga_y <  COORD_W'(V_ACTIVE));
    raddr  = ADDR_W'((in_vga_x - COORD_W'(X_OFFSET)) >> 1);
    show   = in_win && front_valid;
`ifdef LINE_DOUBLER_SCANLINE_EN
    show   = show && !in_vga_y[0];
`endif
  end

  always_ff @(posedge in_clk_25_175_mhz) begin
    if (in_reset) begin
      show_q <= 1'b0;
      sel_q  <= 1'b0;
    end else begin
      show_q <= show;
      sel_q  <= front_sel;
    end
  end

  // front_sel = 0 displays bank 0 and fills bank 1
  mod_line_ram u_bank0 (
    .clk   (in_clk_25_175_mhz),
    .we    (accept && front_sel),
    .waddr (ADDR_W'(waddr)),
    .wdata (rgb_t'(in_wr_rgb)),
    .raddr (raddr),
    .rdata (rd0)
  );

  mod_line_ram u_bank1 (
    .clk   (in_clk_25_175_mhz),
    .we    (accept && !front_sel),
    .waddr (ADDR_W'(waddr)),
    .wdata (rgb_t'(in_wr_rgb)),
    .raddr (raddr),
    .rdata (rd1)
  );

  always_comb begin
    pix = sel_q ? rd1 : rd0;
    if (!show_q) begin
      pix = '0;
    end
  end

  assign out_vga_r = pix.r;
  assign out_vga_g = pix.g;
  assign out_vga_b = pix.b;

endmodule

// File: tb/tb_mod_line_doubler.sv
// Randomized-writer bench for mod_line_doubler against a line-level reference model.
`timescale 1ns/1ps
module tb_mod_line_doubler;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] vx, vy;
  logic       wv;
  logic [2:0] wrgb;
  logic       rdy, lreq;
  logic [7:0] lidx, ucnt;
  logic       r, g, b;

  always #5 clk = ~clk;

  mod_line_doubler dut (
    .in_clk_25_175_mhz  (clk),
    .in_reset           (rst),
    .in_vga_x           (vx),
    .in_vga_y           (vy),
    .in_wr_valid        (wv),
    .in_wr_rgb          (wrgb),
    .out_wr_ready       (rdy),
    .out_line_req       (lreq),
    .out_line_idx       (lidx),
    .out_vga_r          (r),
    .out_vga_g          (g),
    .out_vga_b          (b),
    .out_underrun_count (ucnt)
  );

  int total = 0;
  int bad   = 0;
  int phase = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (y=%0d x=%0d t=%0t)", tag, got, exp, vy, vx, $time);
    end
  endtask

  function automatic int pix(input int line, input int p);
    return (p + 3 * line) & 7;
  endfunction

  // Reference model: source lines as pixel arrays, swaps decided per VGA line rules
  int m_front[256];
  int m_back[256];
  bit m_ok, m_ready, m_req, m_pend, m_sync;
  int m_cnt, m_idx, m_under, m_rgb;

  task automatic model_edge();
    int xi, yi;
    bit is_end, is_odd, fires, acc;
    xi = int'(vx);
    yi = int'(vy);
    if (rst) begin
      m_ok = 0; m_cnt = 0; m_ready = 0; m_req = 0; m_pend = 1;
      m_idx = 0; m_under = 0; m_sync = 1; m_rgb = 0;
      return;
    end
    m_rgb = 0;
    if (m_ok && xi >= 64 && xi < 576 && yi < 480) m_rgb = m_front[(xi - 64) / 2];
`ifdef LINE_DOUBLER_SCANLINE_EN
    if (yi % 2 == 1) m_rgb = 0;
`endif
    acc = wv && m_ready;
    if (acc) begin
      m_back[m_cnt] = int'(wrgb);
      m_cnt++;
      if (m_cnt == 256) m_ready = 0;
    end
    m_req = 0;
    if (m_pend) begin
      m_req = 1; m_ready = 1; m_pend = 0;
    end
    is_end = (xi == 640) && (yi == 524);
    is_odd = (xi == 640) && (yi % 2 == 1) && (yi < 479);
    fires  = is_end || (is_odd && !m_sync);
    if (fires) begin
      if (m_cnt == 256) begin
        m_front = m_back;
        m_ok = 1;
      end else if (m_under < 255) begin
        m_under++;
      end
      m_cnt = 0; m_ready = 0; m_pend = 1;
      m_idx = is_end ? 1 : (((yi + 3) / 2 >= 240) ? 0 : (yi + 3) / 2);
      if (is_end) m_sync = 0;
    end
  endtask

  // Source writer: answers each request with its line, random gaps, one deliberate stall
  int w_line = 0;
  int w_pos  = 0;
  bit w_act = 0, rdy_seen = 0, stall_done = 0;

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("rgb", {r, g, b}, m_rgb);
    check_eq("wr_ready", rdy, m_ready);
    check_eq("line_req", lreq, m_req);
    check_eq("line_idx", lidx, m_idx);
    check_eq("underrun", ucnt, m_under);
    if (rst) begin
      w_act = 0; w_pos = 0;
    end else begin
      if (wv && rdy_seen) w_pos++;
      if (phase == 1 && vy == 10'd9 && vx > 10'd640) stall_done = 1;
      if (lreq) begin
        w_act = 1; w_line = int'(lidx); w_pos = 0;
      end
    end
    rdy_seen = rdy;
    wv   = w_act && (w_pos < 256) && !(w_line == 5 && !stall_done) && ($urandom_range(7) != 0);
    wrgb = 3'(pix(w_line, w_pos));
  endtask

  task automatic directed(input int x, input int y);
    logic [2:0] px;
    px = {r, g, b};
    if (phase == 0 && x == 100) check_eq("sync_black", px, 0);
    if (phase == 1 && y == 0) begin
      if (x == 63)  check_eq("x63_black", px, 0);
      if (x == 64)  check_eq("x64_pix0", px, 0);
      if (x == 65)  check_eq("x65_pix0", px, 0);
      if (x == 66)  check_eq("x66_pix1", px, 1);
      if (x == 67)  check_eq("x67_pix1", px, 1);
      if (x == 575) check_eq("x575_pix255", px, 7);
      if (x == 576) check_eq("x576_black", px, 0);
    end
    if (phase == 1 && y == 9 && x == 641) begin
      check_eq("stall_underrun", ucnt, 1);
      check_eq("stall_req", lreq, 1);
      check_eq("stall_idx6", lidx, 6);
    end
    if (phase == 1 && y == 10 && x == 100) check_eq("repeat_l4_y10", px, pix(4, 18));
`ifdef LINE_DOUBLER_SCANLINE_EN
    if (phase == 1 && y == 11 && x == 100) check_eq("repeat_l4_y11", px, 0);
`else
    if (phase == 1 && y == 11 && x == 100) check_eq("repeat_l4_y11", px, pix(4, 18));
`endif
    if (phase == 1 && y == 12 && x == 100) check_eq("resume_l6", px, pix(6, 18));
    if (phase == 1 && y == 477 && x == 641) begin
      check_eq("y477_req", lreq, 1);
      check_eq("y477_idx0", lidx, 0);
    end
    if (phase == 1 && y == 479 && x == 641) check_eq("y479_noreq", lreq, 0);
    if (phase == 1 && y == 524 && x == 641) begin
      check_eq("y524_req", lreq, 1);
      check_eq("y524_idx1", lidx, 1);
    end
    if (phase == 2 && y == 200 && x == 151) begin
      check_eq("rst_rgb", px, 0);
      check_eq("rst_ready", rdy, 0);
      check_eq("rst_req", lreq, 0);
      check_eq("rst_idx", lidx, 0);
      check_eq("rst_underrun", ucnt, 0);
    end
    if (phase == 2 && y == 200 && x == 153) check_eq("rst_req0", lreq, 1);
    if (phase == 2 && (y == 201 || y == 203) && x == 641) check_eq("sync_ignore_odd", lreq, 0);
    if (phase == 2 && y == 202 && x == 100) check_eq("rst_black", px, 0);
    if (phase == 3 && y == 0 && x == 100) check_eq("resume_l0", px, pix(0, 18));
    if (phase == 3 && y == 2 && x == 100) check_eq("resume_l1", px, pix(1, 18));
  endtask

  task automatic run_line(input int y, input int rst_at);
    for (int x = 40; x <= 680; x++) begin
      vx  = 10'(x);
      vy  = 10'(y);
      rst = (rst_at >= 0) && (x >= rst_at) && (x < rst_at + 3);
      step();
      directed(x, y);
    end
  endtask

  initial begin
    rst = 1'b1; vx = 10'd600; vy = 10'd299; wv = 1'b0; wrgb = 3'd0;
    repeat (3) step();
    check_eq("reset_rgb", {r, g, b}, 0);
    check_eq("reset_ready", rdy, 0);
    check_eq("reset_req", lreq, 0);
    check_eq("reset_idx", lidx, 0);
    check_eq("reset_underrun", ucnt, 0);
    rst = 1'b0; vx = 10'd601;
    step();
    check_eq("first_req", lreq, 1);
    check_eq("first_idx", lidx, 0);
    check_eq("first_ready", rdy, 1);

    phase = 0;
    for (int y = 301; y <= 303; y++) run_line(y, -1);
    run_line(523, -1);
    run_line(524, -1);

    phase = 1;
    for (int y = 0; y <= 13; y++) run_line(y, -1);
    for (int y = 470; y <= 479; y++) run_line(y, -1);
    for (int y = 520; y <= 524; y++) run_line(y, -1);

    phase = 2;
    for (int y = 0; y <= 3; y++) run_line(y, -1);
    run_line(198, -1);
    run_line(199, -1);
    run_line(200, 150);
    for (int y = 201; y <= 203; y++) run_line(y, -1);
    run_line(523, -1);
    run_line(524, -1);

    phase = 3;
    for (int y = 0; y <= 3; y++) run_line(y, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
